// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 2-flop synchronizer, free-running 16x oversample tick,
// start-bit glitch rejection, framing-error detection and break hold-off.
module uart_rx_deframer #(
  parameter int UART_BITS = 8,
  parameter int TICK_DIV  = 163,
  parameter int TICK_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [UART_BITS-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int BCW = $clog2(UART_BITS) + 1;
  localparam logic [TICK_BITS-1:0] DIV_LAST = TICK_BITS'(TICK_DIV - 1);
  localparam logic [BCW-1:0]       BIT_LAST = BCW'(UART_BITS - 1);
  localparam logic [3:0]           MID_CNT  = 4'd7;
  localparam logic [3:0]           END_CNT  = 4'd15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic                 rx_m, rx_s;
  logic [TICK_BITS-1:0] div_cnt;
  logic                 tick;
  logic [2:0]           state;
  logic [3:0]           sample_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [UART_BITS-1:0] shift_reg;

  // Synchronizer resets to the idle (high) level so release never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      sample_cnt    <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      o_rx_data     <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          sample_cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            if (sample_cnt == MID_CNT) begin
              sample_cnt <= '0;
              bit_cnt    <= '0;
              state      <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (sample_cnt == END_CNT) begin
              shift_reg  <= {rx_s, shift_reg[UART_BITS-1:1]};
              sample_cnt <= '0;
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= ST_STOP;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (tick) begin
            if (sample_cnt == END_CNT) begin
              sample_cnt <= '0;
              if (rx_s) begin
                o_rx_data <= shift_reg;
                o_rx_done <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                o_frame_error <= 1'b1;
                state         <= ST_BREAK;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed + randomized frames against a frame-level expectation model of the receiver.
module tb_uart_rx_deframer;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_frame_error, o_busy;

  uart_rx_deframer #(.UART_BITS(8), .TICK_DIV(4), .TICK_BITS(8)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx),
    .o_rx_data(o_rx_data), .o_rx_done(o_rx_done),
    .o_frame_error(o_frame_error), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor: records every observed pulse; judged later by the main sequence.
  int         cyc = 0, ferr_cnt = 0, busy_cyc = 0, width_viol = 0, overlap_viol = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] cap_q[$];
  int         cap_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_rx_done) begin
      cap_q.push_back(o_rx_data);
      cap_cyc.push_back(cyc);
    end
    if (o_frame_error) ferr_cnt <= ferr_cnt + 1;
    if (o_busy) busy_cyc <= busy_cyc + 1;
    if (o_rx_done && o_frame_error) overlap_viol <= overlap_viol + 1;
    if ((o_rx_done || o_frame_error) && prev_pulse) width_viol <= width_viol + 1;
    prev_pulse <= o_rx_done | o_frame_error;
  end

  // Reference model: each well-framed byte is expected once, in order.
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         exp_ferr = 0;
  int         rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(stop, BIT);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_frames(input string tag);
    check(tag, cap_q.size(), exp_q.size());
    while (rd < exp_q.size() && rd < cap_q.size()) begin
      check(tag, {24'h0, cap_q[rd]}, {24'h0, exp_q[rd]});
      rd++;
    end
    check(tag, ferr_cnt, exp_ferr);
    check(tag, {24'h0, o_rx_data}, {24'h0, last_good});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int glen;
    logic [7:0] rb;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", {24'h0, o_rx_data}, 32'h0);
    check("rst_done", {31'h0, o_rx_done}, 32'h0);
    check("rst_ferr", {31'h0, o_frame_error}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    rst = 1'b1;
    drive_bit(1'b1, 50);
    check("idle_busy", {31'h0, o_busy}, 32'h0);

    // Single frame 0xA5, busy must drop in the second half of the stop bit
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(((8'hA5 >> i) & 8'h01) != 0, BIT);
    drive_bit(1'b1, 48);
    check("a5_busy_mid_stop", {31'h0, o_busy}, 32'h0);
    drive_bit(1'b1, 16);
    exp_q.push_back(8'hA5);
    last_good = 8'hA5;
    drive_bit(1'b1, 100);
    check_frames("single_a5");

    // Bad stop bit: error pulse, data keeps 0xA5
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, 100);
    check_frames("bad_stop");
    check("bad_stop_keep", {24'h0, o_rx_data}, 32'hA5);

    // Back-to-back frames, no idle gap
    base = cap_cyc.size();
    send_frame(8'h02, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h78, 1'b1);
    drive_bit(1'b1, 100);
    check_frames("b2b");
    for (int k = 1; k < 5; k++)
      if (base + k < cap_cyc.size())
        check_rng("b2b_spacing", cap_cyc[base+k] - cap_cyc[base+k-1], 636, 644);

    // Glitches: fixed 12 clk then a random short one
    for (int g = 0; g < 2; g++) begin
      glen = (g == 0) ? 12 : int'($urandom_range(1, 20));
      base = busy_cyc;
      drive_bit(1'b0, glen);
      drive_bit(1'b1, 100);
      check_rng("glitch_busy", busy_cyc - base, 1, 60);
      check("glitch_idle", {31'h0, o_busy}, 32'h0);
      check_frames("glitch");
    end
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1, 100);
    check_frames("after_glitch");

    // Random bytes with random idle gaps (including none)
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom_range(0, 255));
      drive_bit(1'b1, $urandom_range(0, 40));
      send_frame(rb, 1'b1);
    end
    drive_bit(1'b1, 100);
    check_frames("random");

    // Break: one frame error, no data, then normal reception
    drive_bit(1'b0, 2000);
    check("break_no_done", cap_q.size(), exp_q.size());
    check("break_busy", {31'h0, o_busy}, 32'h1);
    drive_bit(1'b1, 200);
    exp_ferr++;
    check_frames("break");
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 100);
    check_frames("after_break");

    // Async reset in data bit 4 of 0xFF, between clock edges
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
    drive_bit(1'b1, 30);
    #2 rst = 1'b0;
    #1;
    check("async_data", {24'h0, o_rx_data}, 32'h0);
    check("async_done", {31'h0, o_rx_done}, 32'h0);
    check("async_ferr", {31'h0, o_frame_error}, 32'h0);
    check("async_busy", {31'h0, o_busy}, 32'h0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_bit(1'b1, 100);
    check_frames("post_reset_idle");
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 100);
    check_frames("post_reset");

    check("pulse_width", width_viol, 0);
    check("pulse_overlap", overlap_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
